// File: rtl/reg_write_arbiter_if.sv
// Register-file write arbiter bus: WB request, long-latency result
// handshake, scoreboard lookup and the merged register-file write port.
interface reg_write_arbiter_if;
  logic        wb_reg_write;
  logic [4:0]  wb_wr_reg;
  logic [31:0] wb_wr_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_reg;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        busy1;
  logic        busy2;
  logic        pending;
  logic        reg_write;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  // Pipeline / hazard side drives requests and reads the write port.
  modport master (
    output wb_reg_write, wb_wr_reg, wb_wr_data,
    output lu_issue, lu_issue_reg, lu_valid, lu_reg, lu_data,
    output chk_reg1, chk_reg2,
    input  lu_ready, busy1, busy2, pending, reg_write, wr_reg, wr_data
  );

  // Arbiter side.
  modport slave (
    input  wb_reg_write, wb_wr_reg, wb_wr_data,
    input  lu_issue, lu_issue_reg, lu_valid, lu_reg, lu_data,
    input  chk_reg1, chk_reg2,
    output lu_ready, busy1, busy2, pending, reg_write, wr_reg, wr_data
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Single-write-port arbiter: WB stage has priority, long-latency results
// wait in a one-entry skid buffer. Also tracks pending long-latency
// destinations in a 32-bit scoreboard for the hazard unit.
module reg_write_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  reg_write_arbiter_if.slave   bus
);

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_req_t;

  logic    buf_valid;
  wr_req_t buf_q;
  logic [31:0] sb;
  logic [31:0] sb_set, sb_clr, sb_nxt;

  logic wb_go, lu_acc, lu_wr;

  assign wb_go  = bus.wb_reg_write && (bus.wb_wr_reg != 5'd0);
  assign bus.lu_ready = !buf_valid && !rst;
  assign lu_acc = bus.lu_valid && bus.lu_ready;
  // Accepted result that actually targets a register (r0 results are dropped).
  assign lu_wr  = lu_acc && (bus.lu_reg != 5'd0);

  // Scoreboard next state: clear on the edge a long-latency result reaches
  // the port, set on issue; set wins a same-register race. sb[0] stays 0.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (bus.lu_issue && bus.lu_issue_reg != 5'd0)
      sb_set[bus.lu_issue_reg] = 1'b1;
    if (!wb_go) begin
      if (buf_valid)  sb_clr[buf_q.idx]  = 1'b1;
      else if (lu_wr) sb_clr[bus.lu_reg] = 1'b1;
    end
    sb_nxt = ((sb & ~sb_clr) | sb_set) & 32'hFFFF_FFFE;
  end

  // Write-port selection and skid buffer fill/drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.reg_write <= 1'b0;
      bus.wr_reg    <= 5'd0;
      bus.wr_data   <= 32'd0;
      buf_valid     <= 1'b0;
      buf_q         <= '0;
      sb            <= '0;
    end else begin
      sb <= sb_nxt;
      if (wb_go) begin
        bus.reg_write <= 1'b1;
        bus.wr_reg    <= bus.wb_wr_reg;
        bus.wr_data   <= bus.wb_wr_data;
        // A result accepted under WB priority parks in the buffer.
        if (lu_wr) begin
          buf_valid  <= 1'b1;
          buf_q.idx  <= bus.lu_reg;
          buf_q.data <= bus.lu_data;
        end
      end else if (buf_valid) begin
        bus.reg_write <= 1'b1;
        bus.wr_reg    <= buf_q.idx;
        bus.wr_data   <= buf_q.data;
        buf_valid     <= 1'b0;
      end else if (lu_wr) begin
        bus.reg_write <= 1'b1;
        bus.wr_reg    <= bus.lu_reg;
        bus.wr_data   <= bus.lu_data;
      end else begin
        bus.reg_write <= 1'b0;
      end
    end
  end

  // Combinational lookups; sb[0] is always 0 so index 0 reads not-busy.
  assign bus.busy1   = sb[bus.chk_reg1];
  assign bus.busy2   = sb[bus.chk_reg2];
  assign bus.pending = |sb;

endmodule
